prog_mem_loader: RTL

- Writable 16x8 program memory with a byte-stream loader. It is the write side of the instruction-fetch interface that rom16x8 provides read-only.
- The processor fetches through the addr/data read port, which has the same shape as rom16x8: data = {opcode[7:4], imm[3:0]}.
- A host pushes a program image plus an XOR checksum over a valid/ready handshake.
- The block holds the processor in reset through cpu_rst while loading, and releases it only after a verified image.

---
 rtl/prog_mem_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/prog_mem_loader.sv
// ---------------------------------------------------------------------------
// prog_mem_loader
//   Writable 2**AW x DW program memory with a byte-stream loader. The read
//   side (i_addr -> o_data) has the same shape as the read-only rom16x8
//   fetch port: o_data = {opcode[7:4], imm[3:0]}.
//
//   A host streams LEN image words followed by one XOR checksum byte over a
//   valid/ready handshake. While loading, the processor is held in reset via
//   o_cpu_rst. It is released only after the checksum has been verified.
//
// Ports
//   i_clk         clock, all state updates on the rising edge
//   i_rst         asynchronous active-low reset
//   i_load_start  request a (re)load; honoured only in HALT or RUN
//   i_in_valid    host byte valid
//   o_in_ready    block accepts a byte (LOAD or CHECK)
//   i_in_data     host byte: image word or checksum
//   i_addr        processor fetch address
//   o_data        fetched word, combinational mem[i_addr]
//   o_cpu_rst     active-high hold for program_counter / instruction_decoder
//   o_busy        high in LOAD or CHECK
//   o_done        one-cycle pulse in the first cycle after a load ends
//   o_err         sticky checksum-failure flag
// ---------------------------------------------------------------------------

// One memory word. Cleared by reset, written when i_we is high.
module prog_mem_loader_word #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)     r_q <= '0;
    else if (i_we)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

module prog_mem_loader #(
  parameter int AW  = 4,
  parameter int DW  = 8,
  parameter int LEN = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load_start,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_in_data,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_data,
  output logic          o_cpu_rst,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int DEPTH = 2**AW;

  localparam logic [1:0] S_HALT  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  // wptr carries one extra bit so that LEN == DEPTH still has a distinct
  // last index and never wraps onto address 0.
  localparam logic [AW:0] LAST = (AW+1)'(LEN-1);

  logic [1:0]    r_state;
  logic [AW:0]   r_wptr;
  logic [DW-1:0] r_csum;
  logic          r_done;
  logic          r_err;

  logic          w_active;
  logic          w_idle;
  logic          w_start;
  logic          w_load_hs;
  logic          w_chk_hs;
  logic          w_csum_ok;

  logic [DEPTH-1:0]         w_we;
  logic [DEPTH-1:0][DW-1:0] w_mem;

  assign w_active  = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_idle    = (r_state == S_HALT) || (r_state == S_RUN);
  assign w_start   = i_load_start && w_idle;
  assign w_load_hs = i_in_valid && (r_state == S_LOAD);
  assign w_chk_hs  = i_in_valid && (r_state == S_CHECK);
  assign w_csum_ok = (i_in_data == r_csum);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_HALT;
      r_wptr  <= '0;
      r_csum  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // done lands in the first cycle of RUN or HALT after the check byte
      r_done <= w_chk_hs;
      case (r_state)
        S_HALT, S_RUN: begin
          if (w_start) begin
            r_state <= S_LOAD;
            r_wptr  <= '0;
            r_csum  <= '0;
            r_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_load_hs) begin
            r_wptr <= r_wptr + 1'b1;
            r_csum <= r_csum ^ i_in_data;
            if (r_wptr == LAST) r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_chk_hs) begin
            if (w_csum_ok) begin
              r_state <= S_RUN;
            end else begin
              r_state <= S_HALT;
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Storage: one word cell per address. Only LOAD handshakes write, and
  // wptr never exceeds LEN-1 there, so words at or above LEN are left
  // untouched by a reload. The checksum byte (CHECK) is never stored.
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    assign w_we[g] = w_load_hs && (r_wptr == (AW+1)'(g));

    prog_mem_loader_word #(.DW(DW)) u_word (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_we  (w_we[g]),
      .i_d   (i_in_data),
      .o_q   (w_mem[g])
    );
  end

  // Asynchronous read: a word written on an edge shows up after that edge,
  // and reading the address being written returns the old word until then.
  assign o_data = w_mem[i_addr];

  // Decoded from registered state only, so cpu_rst moves on rising edges
  // and is stable at the processor's falling-edge sample point.
  assign o_cpu_rst  = (r_state != S_RUN);
  assign o_in_ready = w_active;
  assign o_busy     = w_active;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule
